vector_unpacker: RTL and testbench

Serial-in receiver that reassembles a packed vector word of the form {~b, ~a}, two WIDTH-bit fields stored inverted, from a one-bit-per-beat stream. It restores a and b, recomputes their bitwise OR and logical OR, and presents the result on a valid/ready output. It sits at the far end of the serial link that carries packed vectors between units, and is the consumer of the packed form the vector gate logic produces.

---
 rtl/vector_unpacker.sv | 110 +++++++++++
 tb/tb_vector_unpacker.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/vector_unpacker.sv
// vector_unpacker: serial-in receiver that rebuilds a packed {~b, ~a} word,
// restores a and b, and presents a, b, a|b and |{a,b} on a valid/ready port.
// Optional trailing even-parity beat enabled by defining VEC_UNPACK_PARITY_EN.
module vector_unpacker #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic             s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_a,
    output logic [WIDTH-1:0] m_b,
    output logic [WIDTH-1:0] m_or_bitwise,
    output logic             m_or_logical,
    output logic             frame_err
);
    localparam int W2 = 2 * WIDTH;
`ifdef VEC_UNPACK_PARITY_EN
    localparam int N = W2 + 1;
`else
    localparam int N = W2;
`endif
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [W2-1:0]   word_q, word_d, shifted;
    logic [CW-1:0]   count_q, count_d, count_inc;
    logic [WIDTH-1:0] a_q, b_q, orb_q;
    logic            orl_q, err_q, err_d, load, beat, at_end, frame_ok;

    assign s_ready      = state_q != HOLD;
    assign m_valid      = state_q == HOLD;
    assign m_a          = a_q;
    assign m_b          = b_q;
    assign m_or_bitwise = orb_q;
    assign m_or_logical = orl_q;
    assign frame_err    = err_q;

    // Next state: shift data beats, check frame length/parity on the last beat, drain bad frames.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        count_d   = count_q;
        err_d     = 1'b0;
        load      = 1'b0;
        beat      = s_valid && s_ready;
        count_inc = count_q + 1'b1;
        // The parity beat (if any) is checked but never shifted into the word.
        shifted   = (count_q < CW'(W2)) ? {word_q[W2-2:0], s_data} : word_q;
        at_end    = count_inc == CW'(N);
`ifdef VEC_UNPACK_PARITY_EN
        frame_ok  = s_last && ((^word_q) == s_data);
`else
        frame_ok  = s_last;
`endif
        case (state_q)
            IDLE, SHIFT: begin
                if (beat) begin
                    word_d  = shifted;
                    count_d = count_inc;
                    state_d = SHIFT;
                    if (at_end) begin
                        count_d = '0;
                        err_d   = !frame_ok;
                        load    = frame_ok;
                        state_d = frame_ok ? HOLD : (s_last ? IDLE : DRAIN);
                    end else if (s_last) begin
                        count_d = '0;
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            HOLD:    state_d = m_ready ? IDLE : HOLD;
            DRAIN:   state_d = (beat && s_last) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // State, shift register and registered outputs, loaded when a good frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            orb_q   <= '0;
            orl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            count_q <= count_d;
            err_q   <= err_d;
            if (load) begin
                a_q   <= ~shifted[WIDTH-1:0];
                b_q   <= ~shifted[W2-1:WIDTH];
                orb_q <= ~shifted[WIDTH-1:0] | ~shifted[W2-1:WIDTH];
                orl_q <= |(~shifted);
            end
        end
    end
endmodule

// File: tb/tb_vector_unpacker.sv
// tb_vector_unpacker: directed-vector self-checking bench for vector_unpacker (WIDTH=3).
module tb_vector_unpacker;
    logic       clk, rst_n, s_valid, s_data, s_last, s_ready, m_valid, m_ready;
    logic [2:0] m_a, m_b, m_or_bitwise;
    logic       m_or_logical, frame_err;
    int         checks = 0;
    int         errors = 0;
    int         err_cnt = 0;
    int         err_base;

    vector_unpacker #(.WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready), .m_a(m_a), .m_b(m_b),
        .m_or_bitwise(m_or_bitwise), .m_or_logical(m_or_logical), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every cycle frame_err is high, sampled away from the active edge.
    always @(negedge clk) if (frame_err) err_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic frame(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) beat(bits[i], i == 0);
    endtask

    task automatic outs(input string tag, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] o, input logic l);
        chk({tag, "_a"}, m_a, a);
        chk({tag, "_b"}, m_b, b);
        chk({tag, "_orb"}, m_or_bitwise, o);
        chk({tag, "_orl"}, m_or_logical, l);
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_err", frame_err, 0);
        outs("rst", 3'b000, 3'b000, 3'b000, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
`ifdef VEC_UNPACK_PARITY_EN
        m_ready = 1'b1;
        frame(8'b1010101, 7);
        chk("par_good_valid", m_valid, 1);
        chk("par_good_err", frame_err, 0);
        outs("par_good", 3'b101, 3'b010, 3'b111, 1'b1);
        @(posedge clk);
        #1;
        frame(8'b1010100, 7);
        chk("par_bad_err", frame_err, 1);
        chk("par_bad_valid", m_valid, 0);
`else
        // Alternating bits, downstream ready in advance.
        m_ready = 1'b1;
        frame(8'b101010, 6);
        chk("t1_valid", m_valid, 1);
        chk("t1_err", frame_err, 0);
        outs("t1", 3'b101, 3'b010, 3'b111, 1'b1);
        @(posedge clk);
        #1;
        chk("t1_hs_valid", m_valid, 0);
        chk("t1_hs_ready", s_ready, 1);
        // All ones decode to all zeros.
        frame(8'b111111, 6);
        chk("t2_valid", m_valid, 1);
        outs("t2", 3'b000, 3'b000, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        // Short frame: error pulse, no output, then a good frame.
        err_base = err_cnt;
        frame(8'b0110, 4);
        chk("t3_err", frame_err, 1);
        chk("t3_valid", m_valid, 0);
        chk("t3_ready", s_ready, 1);
        @(posedge clk);
        #1;
        chk("t3_err_off", frame_err, 0);
        chk("t3_err_cnt", err_cnt - err_base, 1);
        frame(8'b100110, 6);
        chk("t3_next_valid", m_valid, 1);
        outs("t3_next", 3'b001, 3'b011, 3'b011, 1'b1);
        @(posedge clk);
        #1;
        // Long frame: error after beat 6, beat 7 drained.
        err_base = err_cnt;
        for (int i = 0; i < 6; i++) beat(1'b1, 1'b0);
        chk("t4_err", frame_err, 1);
        beat(1'b0, 1'b1);
        chk("t4_err_off", frame_err, 0);
        chk("t4_valid", m_valid, 0);
        chk("t4_err_cnt", err_cnt - err_base, 1);
        frame(8'b000111, 6);
        chk("t4_next_valid", m_valid, 1);
        outs("t4_next", 3'b000, 3'b111, 3'b111, 1'b1);
        @(posedge clk);
        #1;
        // Backpressure: output held stable while m_ready is low.
        m_ready = 1'b0;
        frame(8'b011001, 6);
        for (int i = 0; i < 5; i++) begin
            chk("t5_valid", m_valid, 1);
            chk("t5_ready", s_ready, 0);
            outs("t5", 3'b110, 3'b100, 3'b110, 1'b1);
            @(posedge clk);
            #1;
        end
        chk("t5_valid6", m_valid, 1);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_hs_ready", s_ready, 1);
        chk("t5_hs_valid", m_valid, 0);
        outs("t5_hold", 3'b110, 3'b100, 3'b110, 1'b1);
        // Asynchronous reset mid-frame.
        err_base = err_cnt;
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        outs("t6_async", 3'b000, 3'b000, 3'b000, 1'b0);
        chk("t6_ready", s_ready, 1);
        chk("t6_valid", m_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_err_cnt", err_cnt - err_base, 0);
        frame(8'b101010, 6);
        chk("t6_next_valid", m_valid, 1);
        outs("t6_next", 3'b101, 3'b010, 3'b111, 1'b1);
`endif
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
